led_wave_gen: RTL

Parametrised LED wave pattern generator. It replaces the fixed 6-LED left, right, up and down wave blocks with one runtime-selectable engine.
- Configurable LED count and per-frame duration.
- Start/retrigger handshake, busy/done status, and a loop mode.
- Sits between the board button/debounce logic and the LED output pins.

---
 rtl/led_wave_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/led_wave_gen.sv
// led_wave_gen: runtime-selectable LED wave pattern generator (RIGHT/LEFT/UP/DOWN)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     single-cycle pulse; begins or retriggers a wave
//   mode      wave select latched on start: 0=RIGHT 1=LEFT 2=UP 3=DOWN
//   loop_en   restart automatically when a sequence completes (sampled at sequence end)
//   step_div  frame length minus 1 in clk cycles, latched on start
//   led       registered LED pattern, bit 0 = rightmost LED
//   busy      high while a sequence (frames or trailing blank) is running
//   done      one-cycle pulse when a sequence completes
//
// Build option: define WAVE_TRAIL_EN to OR the previous frame into led (comet tail).
module led_wave_gen #(
    parameter int N_LEDS = 6,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              loop_en,
    input  logic [DIV_W-1:0]  step_div,
    output logic [N_LEDS-1:0] led,
    output logic              busy,
    output logic              done
);
    localparam int FW = $clog2(N_LEDS);
    localparam logic [1:0] MODE_RIGHT = 2'd0;
    localparam logic [1:0] MODE_LEFT  = 2'd1;
    localparam logic [1:0] MODE_UP    = 2'd2;
    localparam logic [FW-1:0] LAST_LR = FW'(N_LEDS - 1);
    localparam logic [FW-1:0] LAST_UD = FW'((N_LEDS + 1) / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q, mode_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              done_q, done_d;
    logic              adv;
    logic [N_LEDS-1:0] tail;

    function automatic logic [N_LEDS-1:0] pat(input logic [FW-1:0] f, input logic [1:0] m);
        logic [N_LEDS-1:0] p;
        int k;
        k = int'(f);
        for (int i = 0; i < N_LEDS; i++)
            p[i] = (m == MODE_RIGHT) ? (i == N_LEDS - 1 - k) :
                   (m == MODE_LEFT)  ? (i == k) :
                   (m == MODE_UP)    ? (i == (N_LEDS - 1) / 2 - k || i == N_LEDS / 2 + k) :
                                       (i == k || i == N_LEDS - 1 - k);
        return p;
    endfunction

    // Tail is the pattern of the frame being left, only when stepping within a run
    // (including into BLANK); frame 0 and retriggers start with no tail.
`ifdef WAVE_TRAIL_EN
    assign tail = (state_q == RUN && !start) ? pat(frame_q, mode_q) : '0;
`else
    assign tail = '0;
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (start) begin
            state_d = RUN;
            frame_d = '0;
            cnt_d   = '0;
            div_d   = step_div;
            mode_d  = mode;
            adv     = 1'b1;
        end else if (state_q != IDLE) begin
            if (cnt_q == div_q) begin
                cnt_d = '0;
                adv   = 1'b1;
                if (state_q == RUN) begin
                    if (frame_q == (mode_q[1] ? LAST_UD : LAST_LR))
                        state_d = BLANK;
                    else
                        frame_d = frame_q + FW'(1);
                end else begin
                    done_d  = 1'b1;
                    frame_d = '0;
                    state_d = loop_en ? RUN : IDLE;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        // led only moves on frame edges, so it holds otherwise
        led_d = adv ? (((state_d == RUN) ? pat(frame_d, mode_d) : '0) | tail) : led_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            mode_q  <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
endmodule
